serializer_dbuf: RTL and testbench

SERIALIZER_DBUF -- requirements
Module: serializer_dbuf

---
 rtl/serializer_pkg.sv | 14 +
 rtl/serializer_skid.sv | 44 ++++
 rtl/serializer_dbuf.sv | 107 ++++++++++
 tb/tb_serializer_dbuf.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared lane-order type and counter sizing helper for the double-buffered serializer.
package serializer_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } lane_order_e;

  // Beat counter width, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/serializer_skid.sv
// One-word hold buffer: word plus lane-order bit, with its own valid flag.
module serializer_skid
  import serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic                  i_unload,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  lane_order_e           i_order,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output lane_order_e           o_order
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  lane_order_e           order_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
    end else if (i_load) begin
      valid_q <= 1'b1;
    end else if (i_unload) begin
      valid_q <= 1'b0;
    end
  end

  // Payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      data_q  <= i_data;
      order_q <= i_order;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_order = order_q;

endmodule

// File: rtl/serializer_dbuf.sv
// Parallel-to-lane serializer with an active shift slot and a one-word hold slot.
module serializer_dbuf
  import serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANE_WIDTH = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_msb_first,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [LANE_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_busy
);

  localparam int unsigned BEATS = DATA_WIDTH / LANE_WIDTH;
  localparam int unsigned CW    = cnt_width(BEATS);

  generate
    if ((DATA_WIDTH % LANE_WIDTH) != 0 || BEATS < 2) begin : g_bad_cfg
      $fatal(1, "serializer_dbuf: DATA_WIDTH must be a multiple of LANE_WIDTH with at least 2 beats");
    end
  endgenerate

  logic                  active_valid;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] act_word;
  lane_order_e           act_order;

  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_word;
  lane_order_e           hold_order;
  lane_order_e           in_order;

  logic accept, beat, at_last, refill, hold_load, hold_unload;
  logic [CW-1:0] lane_idx;

  assign in_order = i_msb_first ? MSB_FIRST : LSB_FIRST;
  assign o_ready  = !hold_valid;
  assign accept   = i_valid && o_ready;
  assign beat     = active_valid && i_ready;
  assign at_last  = (cnt == CW'(BEATS - 1));
  assign refill   = !active_valid || (beat && at_last);

  // An accepted word bypasses the hold slot only when it goes straight into active.
  assign hold_unload = refill && hold_valid;
  assign hold_load   = accept && !(refill && !hold_valid);

  serializer_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (hold_load),
    .i_unload (hold_unload),
    .i_data   (i_data),
    .i_order  (in_order),
    .o_valid  (hold_valid),
    .o_data   (hold_word),
    .o_order  (hold_order)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active_valid <= 1'b0;
      cnt          <= '0;
    end else if (refill) begin
      active_valid <= hold_valid || accept;
      cnt          <= '0;
    end else if (beat) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (refill) begin
      if (hold_valid) begin
        act_word  <= hold_word;
        act_order <= hold_order;
      end else if (accept) begin
        act_word  <= i_data;
        act_order <= in_order;
      end
    end
  end

  always_comb begin
    lane_idx = cnt;
    o_data   = '0;
    if (act_order == MSB_FIRST) begin
      lane_idx = CW'(BEATS - 1) - cnt;
    end
    if (active_valid) begin
      o_data = LANE_WIDTH'(act_word >> (lane_idx * LANE_WIDTH));
    end
  end

  assign o_valid = active_valid;
  assign o_last  = active_valid && at_last;
  assign o_busy  = active_valid || hold_valid;

endmodule

// File: tb/tb_serializer_dbuf.sv
// Self-checking bench for serializer_dbuf: vector table, directed corner sequences, random vs queue model.
module tb_serializer_dbuf;

  localparam int NB = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_valid, o_ready, i_msb, o_valid, i_ready, o_last, o_busy;
  logic [7:0] i_data;
  logic [0:0] o_data;

  logic        w_valid, w_oready, w_msb, w_ovalid, w_ready, w_last, w_busy;
  logic [15:0] w_data;
  logic [3:0]  w_odata;

  always #5 clk = ~clk;

  serializer_dbuf #(.DATA_WIDTH(8), .LANE_WIDTH(1)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_msb_first(i_msb), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_last(o_last), .o_busy(o_busy)
  );

  serializer_dbuf #(.DATA_WIDTH(16), .LANE_WIDTH(4)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(w_valid), .o_ready(w_oready),
    .i_data(w_data), .i_msb_first(w_msb), .o_valid(w_ovalid), .i_ready(w_ready),
    .o_data(w_odata), .o_last(w_last), .o_busy(w_busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: FIFO of at most two words; front word is the one being shifted.
  typedef struct {
    logic [7:0] w;
    logic       msb;
  } mword_t;
  mword_t mq[$];
  int     mcnt = 0;

  // Packed as {valid, data, last, ready, busy}.
  function automatic logic [4:0] model_out();
    logic v, d, l;
    int   idx;
    v = (mq.size() > 0);
    d = 1'b0;
    l = 1'b0;
    if (v) begin
      idx = mq[0].msb ? (NB - 1 - mcnt) : mcnt;
      d   = mq[0].w[idx];
      l   = (mcnt == NB - 1);
    end
    return {v, d, l, (mq.size() < 2), v};
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic m, input logic r,
                      input string nm, output logic [4:0] seen);
    logic acc, bt;
    @(negedge clk);
    i_valid = v; i_data = d; i_msb = m; i_ready = r;
    #1;
    seen = {o_valid, o_data, o_last, o_ready, o_busy};
    check(nm, seen, model_out());
    acc = v && (mq.size() < 2);
    bt  = (mq.size() > 0) && r;
    @(posedge clk);
    if (bt) begin
      if (mcnt == NB - 1) begin
        void'(mq.pop_front());
        mcnt = 0;
      end else begin
        mcnt++;
      end
    end
    if (acc) mq.push_back('{w: d, msb: m});
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       m;
    logic       r;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[19];

  logic lsb_bits[8] = '{0, 1, 1, 1, 1, 0, 0, 0};
  logic msb_bits[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
  logic [3:0] nib_lsb[4] = '{4'hD, 4'hC, 4'hB, 4'hA};
  logic [3:0] nib_msb[4] = '{4'hA, 4'hB, 4'hC, 4'hD};
  logic [7:0] words3[3] = '{8'h12, 8'h34, 8'h56};

  initial begin
    logic [4:0] s;
    int k, nvalid, first_v, last_v, busy_fall, ready_low;
    logic acc_pre;

    rst_n = 1'b0;
    i_valid = 0; i_data = '0; i_msb = 0; i_ready = 0;
    w_valid = 0; w_data = '0; w_msb = 0; w_ready = 0;
    #12;
    check("reset_state", {o_valid, o_data, o_last, o_ready, o_busy}, 5'b00010);
    check("reset_state16", {w_ovalid, w_odata, w_last, w_oready, w_busy}, 8'b00000010);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: 0x1E LSB-first then MSB-first, i_ready held high.
    tbl[0] = '{v: 1, d: 8'h1E, m: 0, r: 1, exp: 5'b00010};
    for (int i = 0; i < 8; i++)
      tbl[1 + i] = '{v: 0, d: 8'h00, m: 0, r: 1, exp: {1'b1, lsb_bits[i], (i == 7), 2'b11}};
    tbl[9] = '{v: 1, d: 8'h1E, m: 1, r: 1, exp: 5'b00010};
    for (int i = 0; i < 8; i++)
      tbl[10 + i] = '{v: 0, d: 8'hFF, m: 0, r: 1, exp: {1'b1, msb_bits[i], (i == 7), 2'b11}};
    tbl[18] = '{v: 0, d: 8'h00, m: 0, r: 1, exp: 5'b00010};
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      i_valid = tbl[i].v; i_data = tbl[i].d; i_msb = tbl[i].m; i_ready = tbl[i].r;
      #1;
      check($sformatf("vec%0d", i), {o_valid, o_data, o_last, o_ready, o_busy}, tbl[i].exp);
    end

    // Back-to-back words with i_valid held: contiguous beats, hold back-pressure.
    k = 0; nvalid = 0; first_v = -1; last_v = -1; busy_fall = -1; ready_low = 0;
    for (int c = 0; c < 30; c++) begin
      acc_pre = (k < 3) && (mq.size() < 2);
      step(k < 3, (k < 3) ? words3[k] : 8'($urandom), 1'b0, 1'b1, "b2b", s);
      if (acc_pre) k++;
      if (s[4]) begin
        nvalid++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (!s[1]) ready_low++;
      if (!s[0] && last_v >= 0 && busy_fall < 0) busy_fall = c;
    end
    check("b2b_beats", nvalid, 24);
    check("b2b_first", first_v, 1);
    check("b2b_contig", last_v - first_v + 1, 24);
    check("b2b_ready_low", ready_low, 14);
    check("b2b_busy_fall", busy_fall, last_v + 1);

    // Downstream stall at beat 3 of 0xA5.
    step(1, 8'hA5, 0, 1, "stall", s);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, "stall", s);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'($urandom), 1'($urandom), 0, "stall", s);
      check("stall_frozen", s, 5'b10011);
    end
    for (int i = 0; i < 6; i++) step(0, 8'h00, 0, 1, "resume", s);

    // Asynchronous reset at beat 4 with the hold slot full.
    step(1, 8'h3C, 0, 1, "rst_pre", s);
    step(1, 8'hC3, 1, 1, "rst_pre", s);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, "rst_pre", s);
    check("rst_pre_full", {o_valid, o_last, o_ready, o_busy}, 4'b1001);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {o_valid, o_data, o_last, o_ready, o_busy}, 5'b00010);
    mq.delete();
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h81, 1, 1, "rst_post", s);
    for (int i = 0; i < 9; i++) step(0, 8'h00, 0, 1, "rst_post", s);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
           1'($urandom_range(0, 3) != 0), "rand", s);
    for (int i = 0; i < 20; i++) step(0, 8'h00, 0, 1, "drain", s);

    // 16-bit word, 4-bit lanes, both orders.
    for (int o = 0; o < 2; o++) begin
      @(negedge clk);
      w_valid = 1; w_data = 16'hABCD; w_msb = 1'(o); w_ready = 1;
      @(negedge clk);
      w_valid = 0; w_data = 16'h0000;
      for (int i = 0; i < 4; i++) begin
        #1;
        check($sformatf("w16_o%0d_b%0d", o, i), {w_ovalid, w_odata, w_last},
              {1'b1, (o == 0) ? nib_lsb[i] : nib_msb[i], (i == 3)});
        @(negedge clk);
      end
      #1;
      check("w16_idle", {w_ovalid, w_busy, w_oready}, 3'b001);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
